hbf_decim: RTL and testbench

HBF_DECIM -- requirements
Module: hbf_decim

---
 rtl/hbf_decim_if.sv | 30 +++
 rtl/hbf_decim.sv | 158 +++++++++++++++
 tb/tb_hbf_decim.sv | 537 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hbf_decim_if.sv
// hbf_decim_if: sample, coefficient and status bundle
// for the half-band decimator.
interface hbf_decim_if #(
   parameter int DW = 33,
   parameter int CW = 16,
   parameter int AW = 2
);
   logic signed [DW-1:0] in;
   logic                 valid_in;
   logic                 bypass;
   logic                 coef_we;
   logic [AW-1:0]        coef_addr;
   logic signed [CW-1:0] coef_data;
   logic signed [DW-1:0] out;
   logic                 valid_out;
   logic                 busy;
   logic                 overrun;

   modport master (
      output in, valid_in, bypass,
      output coef_we, coef_addr, coef_data,
      input  out, valid_out, busy, overrun
   );

   modport slave (
      input  in, valid_in, bypass,
      input  coef_we, coef_addr, coef_data,
      output out, valid_out, busy, overrun
   );
endinterface

// File: rtl/hbf_decim.sv
// hbf_decim: symmetric half-band decimate-by-2 with a serial
// pre-add/MAC, runtime coefficients, bypass and overrun flag.
module hbf_decim #(
   parameter int DW   = 33,
   parameter int CW   = 16,
   parameter int NTAP = 7,
   parameter int FRAC = 15,
   parameter logic [((NTAP+1)/4+1)*CW-1:0] C_INIT =
      {16'sd16384, 16'sd10053, -16'sd2761}
) (
   input logic        clk,
   input logic        rst,
   hbf_decim_if.slave s
);
   localparam int NS   = (NTAP+1)/4;
   localparam int AW   = $clog2(NS+1);
   localparam int MID  = (NTAP-1)/2;
   localparam int PW   = DW+1+CW;
   localparam int ACCW = PW + $clog2(NS+1);

   localparam logic signed [ACCW:0] MAXV =
      {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW:0] MINV =
      {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};
   localparam logic signed [ACCW:0] RND =
      {{ACCW{1'b0}}, 1'b1} << (FRAC-1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic signed [DW-1:0]   r_w [NTAP];
   logic signed [CW-1:0]   r_c [NS+1];
   logic signed [DW:0]     w_pre [NS+1];
   logic signed [CW-1:0]   w_cm;
   logic signed [DW:0]     w_pm;
   logic signed [PW-1:0]   w_prod;
   logic signed [ACCW-1:0] r_acc;
   logic signed [ACCW:0]   w_rnd;
   logic signed [ACCW:0]   w_shf;
   logic signed [DW-1:0]   w_sat;
   logic signed [DW-1:0]   r_out;
   logic [AW-1:0]          r_cnt;
   logic                   r_phase;
   logic                   r_bpend;
   logic                   r_vout;
   logic                   r_ovr;
   logic                   w_busy;
   logic                   w_acc;
   logic                   w_start;
   logic                   w_bstart;
   logic                   w_cwe;

   assign w_busy   = (r_state != S_IDLE);
   assign w_acc    = s.valid_in & ~w_busy;
   assign w_start  = w_acc & r_phase & ~s.bypass;
   assign w_bstart = w_acc & r_phase & s.bypass;
   assign w_cwe    = s.coef_we & ~w_busy &
                     (s.coef_addr <= AW'(NS));

   // symmetric taps share one multiply via a pre-adder
   for (genvar j = 0; j < NS; j++) begin : g_pre
      assign w_pre[j] =
         {r_w[2*j][DW-1], r_w[2*j]} +
         {r_w[NTAP-1-2*j][DW-1], r_w[NTAP-1-2*j]};
   end
   assign w_pre[NS] = {r_w[MID][DW-1], r_w[MID]};

   assign w_cm   = r_c[r_cnt];
   assign w_pm   = w_pre[r_cnt];
   assign w_prod = $signed({{(DW+1){w_cm[CW-1]}}, w_cm}) *
                   $signed({{CW{w_pm[DW]}}, w_pm});

   assign w_rnd = {r_acc[ACCW-1], r_acc} + RND;
   assign w_shf = w_rnd >>> FRAC;

   always_comb begin
      w_sat = w_shf[DW-1:0];
      if (w_shf > MAXV)
         w_sat = MAXV[DW-1:0];
      else if (w_shf < MINV)
         w_sat = MINV[DW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:
            if (w_start) w_state_nxt = S_MAC;
         S_MAC:
            if (r_cnt == AW'(NS)) w_state_nxt = S_OUT;
         S_OUT:
            w_state_nxt = S_IDLE;
         default:
            w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NTAP; i++)
            r_w[i] <= '0;
         for (int i = 0; i <= NS; i++)
            r_c[i] <= C_INIT[i*CW +: CW];
         r_acc   <= '0;
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_bpend <= 1'b0;
         r_vout  <= 1'b0;
         r_ovr   <= 1'b0;
         r_out   <= '0;
      end else begin
         r_vout  <= 1'b0;
         r_bpend <= w_bstart;
         if (w_acc) begin
            r_w[0] <= s.in;
            for (int k = 1; k < NTAP; k++)
               r_w[k] <= r_w[k-1];
            r_phase <= ~r_phase;
         end
         if (s.valid_in & w_busy)
            r_ovr <= 1'b1;
         if (w_cwe)
            r_c[s.coef_addr] <= s.coef_data;
         if (w_start) begin
            r_acc <= '0;
            r_cnt <= '0;
         end
         if (r_state == S_MAC) begin
            r_acc <= r_acc +
               {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
            r_cnt <= r_cnt + AW'(1);
         end
         if (r_state == S_OUT) begin
            r_out  <= w_sat;
            r_vout <= 1'b1;
         end
         // r_w[0] still holds the bypass sample one edge later
         if (r_bpend) begin
            r_out  <= r_w[0];
            r_vout <= 1'b1;
         end
      end
   end

   assign s.out       = r_out;
   assign s.valid_out = r_vout;
   assign s.busy      = w_busy;
   assign s.overrun   = r_ovr;
endmodule

// File: tb/tb_hbf_decim.sv
// tb_hbf_decim: randomized and directed checks of hbf_decim
// against a sum-of-products reference model.
module tb_hbf_decim;
   localparam int DW   = 33;
   localparam int CW   = 16;
   localparam int NTAP = 7;
   localparam int NS   = 2;
   localparam int MID  = 3;
   localparam int FRAC = 15;
   localparam int AW   = 2;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   longint hist [NTAP];
   longint mc [NS+1];
   bit     mph;

   hbf_decim_if #(.DW(DW), .CW(CW), .AW(AW)) io ();

   hbf_decim #(
      .DW(DW), .CW(CW), .NTAP(NTAP), .FRAC(FRAC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s  (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic void mdl_reset();
      for (int i = 0; i < NTAP; i++) hist[i] = 0;
      mph   = 1'b0;
      mc[0] = -2761;
      mc[1] = 10053;
      mc[2] = 16384;
   endfunction

   // returns the phase the sample was accepted in
   function automatic bit mdl_shift(longint x);
      bit p;
      for (int k = NTAP-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      p   = mph;
      mph = ~mph;
      return p;
   endfunction

   function automatic longint ref_y();
      longint y;
      y = 0;
      for (int j = 0; j < NS; j++)
         y += mc[j] * (hist[2*j] + hist[NTAP-1-2*j]);
      y += mc[NS] * hist[MID];
      return y;
   endfunction

   function automatic longint ref_out(longint y);
      longint q;
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (DW-1)) - 1;
      lo = -(longint'(1) <<< (DW-1));
      q  = (y + (longint'(1) <<< (FRAC-1))) >>> FRAC;
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return q;
   endfunction

   function automatic longint rnd_s();
      logic signed [DW-1:0] r;
      r = {1'($urandom_range(0, 1)), 32'($urandom)};
      return longint'(r);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mdl_reset();
   endtask

   task automatic wr_coef(input int a, input longint d,
                          input bit upd);
      @(negedge clk);
      io.coef_we   = 1'b1;
      io.coef_addr = AW'(a);
      io.coef_data = CW'(d);
      @(posedge clk);
      #1;
      io.coef_we = 1'b0;
      if (upd) mc[a] = longint'($signed(CW'(d)));
   endtask

   task automatic push(input longint x, input bit byp,
                       output bit got, output longint gv);
      bit     was;
      bit     filt;
      int     lat;
      int     nv;
      int     vk;
      longint vo;
      longint e;
      logic   b0;
      logic   bl;
      @(negedge clk);
      io.in       = x[DW-1:0];
      io.valid_in = 1'b1;
      io.bypass   = byp;
      @(posedge clk);
      #1;
      io.valid_in = 1'b0;
      b0   = io.busy;
      was  = mdl_shift(x);
      filt = was & ~byp;
      lat  = !was ? -1 : (byp ? 1 : NS+2);
      e    = byp ? x : ref_out(ref_y());
      nv = 0;
      vk = -1;
      vo = 0;
      bl = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         if (io.valid_out === 1'b1) begin
            nv++;
            if (vk < 0) begin
               vk = k;
               vo = longint'(io.out);
            end
         end
         if (k == lat) bl = io.busy;
      end
      checks++;
      if (b0 !== filt) begin
         failures++;
         $display("FAIL push_busy: got %b want %b", b0, filt);
      end
      checks++;
      if (vk != lat) begin
         failures++;
         $display("FAIL push_vcycle: got %0d want %0d", vk, lat);
      end
      checks++;
      if (nv != ((lat > 0) ? 1 : 0)) begin
         failures++;
         $display("FAIL push_vcount: got %0d want %0d",
                  nv, (lat > 0) ? 1 : 0);
      end
      if (lat > 0) begin
         checks++;
         if (vo != e) begin
            failures++;
            $display("FAIL push_out: got %0d want %0d", vo, e);
         end
         checks++;
         if (bl !== 1'b0) begin
            failures++;
            $display("FAIL push_busy_end: got %b want 0", bl);
         end
      end
      got = (vk > 0);
      gv  = vo;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (io.out !== '0) begin
         failures++;
         $display("FAIL rst_out: got %0d want 0", io.out);
      end
      checks++;
      if (io.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL rst_vout: got %b want 0", io.valid_out);
      end
      checks++;
      if (io.busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_busy: got %b want 0", io.busy);
      end
      checks++;
      if (io.overrun !== 1'b0) begin
         failures++;
         $display("FAIL rst_ovr: got %b want 0", io.overrun);
      end
      @(negedge clk);
      rst = 1'b0;
      mdl_reset();
   endtask

   task automatic test_impulse();
      longint q [$];
      longint ex [5];
      bit     g;
      longint v;
      ex = '{-2761, 10053, 10053, -2761, 0};
      do_reset();
      push(0, 1'b0, g, v);
      push(32768, 1'b0, g, v);
      if (g) q.push_back(v);
      for (int i = 0; i < 10; i++) begin
         push(0, 1'b0, g, v);
         if (g) q.push_back(v);
      end
      checks++;
      if (q.size() < 5) begin
         failures++;
         $display("FAIL imp_count: got %0d want >=5", q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (q[i] != ex[i]) begin
               failures++;
               $display("FAIL imp_out%0d: got %0d want %0d",
                        i, q[i], ex[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      bit     g;
      longint v;
      longint x;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a <= NS; a++)
            wr_coef(a, longint'($urandom_range(0, 65535)), 1'b1);
         for (int i = 0; i < 24; i++) begin
            x = rnd_s();
            if ($urandom_range(0, 1) == 1) x = x >>> 12;
            push(x, ($urandom_range(0, 3) == 0), g, v);
         end
      end
   endtask

   task automatic test_saturation();
      bit     g;
      longint v;
      longint last;
      longint pmax;
      longint nmin;
      pmax = (longint'(1) <<< 32) - 1;
      nmin = -(longint'(1) <<< 32);
      do_reset();
      for (int a = 0; a <= NS; a++) wr_coef(a, 32767, 1'b1);
      last = 0;
      for (int i = 0; i < 10; i++) begin
         push(pmax, 1'b0, g, v);
         if (g) last = v;
      end
      checks++;
      if (last != pmax) begin
         failures++;
         $display("FAIL sat_pos: got %0d want %0d", last, pmax);
      end
      for (int i = 0; i < 10; i++) begin
         push(nmin, 1'b0, g, v);
         if (g) last = v;
      end
      checks++;
      if (last != nmin) begin
         failures++;
         $display("FAIL sat_neg: got %0d want %0d", last, nmin);
      end
   endtask

   task automatic test_rounding();
      bit     g;
      longint v;
      do_reset();
      wr_coef(0, 0, 1'b1);
      wr_coef(1, 0, 1'b1);
      wr_coef(2, 1, 1'b1);
      push(16384, 1'b0, g, v);
      push(0, 1'b0, g, v);
      push(0, 1'b0, g, v);
      push(0, 1'b0, g, v);
      checks++;
      if (!g || v != 1) begin
         failures++;
         $display("FAIL rnd_pos: got %0d want 1", v);
      end
      push(-16384, 1'b0, g, v);
      push(0, 1'b0, g, v);
      push(0, 1'b0, g, v);
      push(0, 1'b0, g, v);
      checks++;
      if (!g || v != 0) begin
         failures++;
         $display("FAIL rnd_neg: got %0d want 0", v);
      end
   endtask

   task automatic test_bypass();
      bit     g;
      longint v;
      do_reset();
      push(5, 1'b1, g, v);
      push(7, 1'b1, g, v);
      checks++;
      if (!g || v != 7) begin
         failures++;
         $display("FAIL byp_first: got %0d want 7", v);
      end
      push(9, 1'b1, g, v);
      push(11, 1'b1, g, v);
      checks++;
      if (!g || v != 11) begin
         failures++;
         $display("FAIL byp_second: got %0d want 11", v);
      end
      io.bypass = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit     g;
      bit     p;
      longint v;
      longint b;
      longint e;
      int     vk;
      longint vo;
      do_reset();
      push(rnd_s(), 1'b0, g, v);
      b = rnd_s();
      @(negedge clk);
      io.in       = b[DW-1:0];
      io.valid_in = 1'b1;
      io.bypass   = 1'b0;
      @(posedge clk);
      #1;
      io.in = DW'(rnd_s());
      p = mdl_shift(b);
      e = ref_out(ref_y());
      checks++;
      if (io.busy !== 1'b1) begin
         failures++;
         $display("FAIL ovr_busy: got %b want 1", io.busy);
      end
      checks++;
      if (io.overrun !== 1'b0) begin
         failures++;
         $display("FAIL ovr_pre: got %b want 0", io.overrun);
      end
      @(posedge clk);
      #1;
      io.in = DW'(rnd_s());
      checks++;
      if (io.overrun !== 1'b1) begin
         failures++;
         $display("FAIL ovr_set: got %b want 1", io.overrun);
      end
      @(posedge clk);
      #1;
      io.valid_in = 1'b0;
      vk = -1;
      vo = 0;
      for (int k = 3; k <= 7; k++) begin
         @(posedge clk);
         #1;
         if (io.valid_out === 1'b1 && vk < 0) begin
            vk = k;
            vo = longint'(io.out);
         end
      end
      checks++;
      if (vk != 4) begin
         failures++;
         $display("FAIL ovr_vcycle: got %0d want 4", vk);
      end
      checks++;
      if (vo != e) begin
         failures++;
         $display("FAIL ovr_out: got %0d want %0d", vo, e);
      end
      push(rnd_s(), 1'b0, g, v);
      push(rnd_s(), 1'b0, g, v);
      checks++;
      if (io.overrun !== 1'b1) begin
         failures++;
         $display("FAIL ovr_hold: got %b want 1", io.overrun);
      end
      do_reset();
      #1;
      checks++;
      if (io.overrun !== 1'b0) begin
         failures++;
         $display("FAIL ovr_clear: got %b want 0", io.overrun);
      end
   endtask

   task automatic test_reset_mid_mac();
      bit     g;
      bit     p;
      longint v;
      int     nv;
      do_reset();
      push(100000, 1'b0, g, v);
      push(-300000, 1'b0, g, v);
      push(rnd_s(), 1'b0, g, v);
      @(negedge clk);
      io.in       = DW'(rnd_s());
      io.valid_in = 1'b1;
      @(posedge clk);
      #1;
      io.valid_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (io.busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_busy: got %b want 0", io.busy);
      end
      checks++;
      if (io.out !== '0) begin
         failures++;
         $display("FAIL mid_out: got %0d want 0", io.out);
      end
      checks++;
      if (io.valid_out !== 1'b0) begin
         failures++;
         $display("FAIL mid_vout: got %b want 0", io.valid_out);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mdl_reset();
      nv = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (io.valid_out === 1'b1) nv++;
      end
      checks++;
      if (nv != 0) begin
         failures++;
         $display("FAIL mid_novalid: got %0d want 0", nv);
      end
      push(rnd_s(), 1'b0, g, v);
      push(rnd_s(), 1'b0, g, v);
      checks++;
      if (!g) begin
         failures++;
         $display("FAIL mid_resume: got %b want 1", g);
      end
   endtask

   task automatic test_coef_lock();
      bit     g;
      bit     p;
      longint v;
      longint b;
      longint e;
      int     vk;
      longint vo;
      do_reset();
      wr_coef(3, 0, 1'b0);
      push(rnd_s(), 1'b0, g, v);
      b = rnd_s();
      @(negedge clk);
      io.in       = b[DW-1:0];
      io.valid_in = 1'b1;
      @(posedge clk);
      #1;
      io.valid_in  = 1'b0;
      io.coef_we   = 1'b1;
      io.coef_addr = '0;
      io.coef_data = '0;
      p = mdl_shift(b);
      e = ref_out(ref_y());
      @(posedge clk);
      #1;
      io.coef_we = 1'b0;
      vk = -1;
      vo = 0;
      for (int k = 2; k <= 7; k++) begin
         @(posedge clk);
         #1;
         if (io.valid_out === 1'b1 && vk < 0) begin
            vk = k;
            vo = longint'(io.out);
         end
      end
      checks++;
      if (vk != 4 || vo != e) begin
         failures++;
         $display("FAIL lock_out: got %0d@%0d want %0d@4",
                  vo, vk, e);
      end
      push(rnd_s(), 1'b0, g, v);
      push(rnd_s(), 1'b0, g, v);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      io.in        = '0;
      io.valid_in  = 1'b0;
      io.bypass    = 1'b0;
      io.coef_we   = 1'b0;
      io.coef_addr = '0;
      io.coef_data = '0;
      mdl_reset();
      test_reset();
      test_impulse();
      test_random();
      test_saturation();
      test_rounding();
      test_bypass();
      test_back_to_back();
      test_reset_mid_mac();
      test_coef_lock();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end
endmodule
